ch_trigger_conditioner: RTL and testbench
=========================================

Name: ch_trigger_conditioner

Overview:
Sits directly upstream of the channel state machine. Turns the raw, asynchronous discriminator output into the clean, fixed-width `trigger` pulse that advances the sampling state.
- Synchronises the input, detects rising edges, and gates them by the channel's current state.
- Enforces a programmable holdoff (dead time) between triggers.
- Counts edges that arrive while it is busy.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on DISC (legal values 2 or 3)
PULSE_W, 2, width of the trigger pulse in CLK cycles (legal values 1 to 15)
HOLDOFF_W, 8, width of the HOLDOFF configuration and its down-counter

Ports:
CLK  input  1  channel clock
RSTB  input  1  reset, asynchronous, active-low
DISC  input  1  raw discriminator output, asynchronous to CLK
TRIG_EN  input  1  global trigger enable (quasi-static config)
HOLDOFF  input  HOLDOFF_W  dead-time cycles after a pulse ends; sampled at pulse start
current_state  input  state_t  state fed back from the channel state machine, used for gating
CLR_MISSED  input  1  synchronous clear of missed_cnt, one CLK cycle
trigger  output  1  conditioned trigger pulse, registered
busy  output  1  high in FIRE or HOLDOFF
missed_cnt  output  8  saturating count of edges rejected while busy

Behaviour:
- Reset (RSTB low, asynchronous):
  - FSM goes to IDLE.
  - trigger=0, busy=0, missed_cnt=0.
  - All synchroniser and edge-detect flops go to 0.
  - Reset asserted mid-pulse truncates the pulse immediately.
- Synchroniser and edge detect:
  - DISC passes through SYNC_STAGES flops; a further flop holds the previous value.
  - edge = sync_out AND NOT prev.
- Armed condition: TRIG_EN=1 AND current_state is one of SAMPLING_A, SAMPLING_B, SAMPLING_C, SAMPLING_D, SAMPLING_A_AND_B, SAMPLING_C_AND_D, SAMPLING_ALL.
  - Not armed in INIT, STOPPED, READOUT, SAMPLING_E.
- FSM states: IDLE, FIRE, HOLDOFF.
  - IDLE, edge and armed: go to FIRE. Register trigger=1, load pulse counter with PULSE_W-1, latch HOLDOFF.
  - IDLE, edge and not armed: ignored. Stay in IDLE; missed_cnt unchanged.
  - FIRE: trigger stays 1 for exactly PULSE_W cycles.
    - When the counter reaches 0: go to HOLDOFF if the latched HOLDOFF is nonzero, otherwise to IDLE. trigger goes 0 on that transition.
  - HOLDOFF: trigger=0. Count down the latched value; go to IDLE after exactly HOLDOFF cycles.
- Latency: if DISC is low at CLK edge n-1 and high at edge n, trigger is high after edge n+SYNC_STAGES (IDLE, armed).
- Pulse is never truncated by changes in TRIG_EN or current_state during FIRE. The downstream state machine is edge-triggered, so a full pulse is required.
- A new edge requires DISC to return low first. A level held high produces exactly one pulse.
- missed_cnt:
  - Increments on any edge while in FIRE or HOLDOFF, regardless of armed.
  - Saturates at 255.
  - CLR_MISSED has priority: an edge in the same cycle as a clear gives 0.
- Boundary: an edge in the last HOLDOFF cycle (the one that transitions to IDLE) is counted as missed and does not fire.
- Boundary: HOLDOFF=0 allows back-to-back pulses separated only by the DISC low time. Minimum trigger period is PULSE_W+1 cycles.
- A HOLDOFF change while in HOLDOFF does not affect the current dead time.

Decomposition:
- types_pkg:
  - add enum tc_state_t {TC_IDLE, TC_FIRE, TC_HOLDOFF};
  - add function is_sampling_state(state_t) returning the armed-state set, shared by gating logic elsewhere.
- state_t is reused from types_pkg unchanged.
- One sub-module: ch_sync, a parameterised N-flop synchroniser with RSTB and CLK. It is reused for the INST_* lines in later blocks.

Test Plan:
- Arming and latency: RSTB released, TRIG_EN=1, current_state=SAMPLING_A, DISC goes high at edge 10 (defaults) -> trigger high after edges 12 and 13, low after 14; busy high for 2+HOLDOFF cycles.
- Holdoff rejection: HOLDOFF=8, DISC pulses at edges 10 and 16 -> one trigger; missed_cnt=1. A third DISC pulse at edge 30 -> second trigger, missed_cnt stays 1.
- Gating: current_state=SAMPLING_E, then READOUT, then STOPPED, then TRIG_EN=0 with SAMPLING_ALL; 4 DISC pulses -> trigger never high, missed_cnt=0.
- HOLDOFF=0 back-to-back: DISC toggles every 3 cycles for 5 edges -> 5 trigger pulses, each 2 cycles wide.
- Saturation and clear: 300 DISC pulses during a HOLDOFF=255 window -> missed_cnt=255. Assert CLR_MISSED in the same cycle as a rejected edge -> missed_cnt=0.
- Reset mid-pulse: RSTB low one cycle after trigger rises -> trigger=0 immediately. After release with DISC still high -> no trigger until DISC falls and rises again.

Source files
------------

// File: rtl/types_pkg.sv
// Shared channel types: channel state encoding, trigger-conditioner FSM states,
// and the armed-state helper used by gating logic across the channel.
package types_pkg;

  typedef enum logic [3:0] {
    INIT             = 4'd0,
    SAMPLING_A       = 4'd1,
    SAMPLING_B       = 4'd2,
    SAMPLING_C       = 4'd3,
    SAMPLING_D       = 4'd4,
    SAMPLING_E       = 4'd5,
    SAMPLING_A_AND_B = 4'd6,
    SAMPLING_C_AND_D = 4'd7,
    SAMPLING_ALL     = 4'd8,
    READOUT          = 4'd9,
    STOPPED          = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    TC_IDLE    = 2'd0,
    TC_FIRE    = 2'd1,
    TC_HOLDOFF = 2'd2
  } tc_state_t;

  localparam int unsigned MISSED_W   = 8;
  localparam logic [7:0]  MISSED_MAX = 8'd255;

  // True for the channel states in which a trigger may advance sampling.
  // SAMPLING_E is deliberately excluded.
  function automatic logic is_sampling_state(input state_t st);
    logic armed;
    case (st)
      SAMPLING_A, SAMPLING_B, SAMPLING_C, SAMPLING_D,
      SAMPLING_A_AND_B, SAMPLING_C_AND_D, SAMPLING_ALL: armed = 1'b1;
      default:                                          armed = 1'b0;
    endcase
    return armed;
  endfunction

endpackage

// File: rtl/ch_sync.sv
// Parameterised N-flop synchroniser for an asynchronous single-bit input.
module ch_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RSTB,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the raw input through the flop chain; all stages clear on reset.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/ch_trigger_conditioner.sv
// Conditions the raw discriminator output into a fixed-width trigger pulse:
// synchronise, rising-edge detect, gate by channel state, enforce a holdoff
// dead time and count edges rejected while busy.
module ch_trigger_conditioner
  import types_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_W     = 2,
  parameter int unsigned HOLDOFF_W   = 8
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 DISC,
  input  logic                 TRIG_EN,
  input  logic [HOLDOFF_W-1:0] HOLDOFF,
  input  state_t               current_state,
  input  logic                 CLR_MISSED,
  output logic                 trigger,
  output logic                 busy,
  output logic [MISSED_W-1:0]  missed_cnt
);

  localparam logic [3:0]           PULSE_LOAD = 4'(PULSE_W - 1);
  localparam logic [2:0]           WARM_DONE  = 3'(SYNC_STAGES + 1);
  localparam logic [HOLDOFF_W-1:0] HO_ONE     = HOLDOFF_W'(1);
  localparam logic [HOLDOFF_W-1:0] HO_ZERO    = HOLDOFF_W'(0);

  logic                 sync_out_s;
  logic                 prev_r;
  logic [2:0]           warm_r;
  logic                 edge_s;
  logic                 armed_s;
  tc_state_t            state_r;
  tc_state_t            state_n_s;
  logic [3:0]           pcnt_r;
  logic [3:0]           pcnt_n_s;
  logic [HOLDOFF_W-1:0] ho_cnt_r;
  logic [HOLDOFF_W-1:0] ho_cnt_n_s;
  logic                 trigger_r;
  logic                 busy_r;
  logic [MISSED_W-1:0]  missed_r;

  ch_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK  (CLK),
    .RSTB (RSTB),
    .d    (DISC),
    .q    (sync_out_s)
  );

  // Previous synchronised value for edge detection, plus a warm-up counter
  // so a level already high across reset is not mistaken for a fresh edge:
  // edges are honoured only once prev holds a genuine post-reset sample.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      prev_r <= 1'b0;
      warm_r <= 3'd0;
    end else begin
      prev_r <= sync_out_s;
      if (warm_r != WARM_DONE) begin
        warm_r <= warm_r + 3'd1;
      end else begin
        warm_r <= warm_r;
      end
    end
  end

  assign edge_s  = sync_out_s & ~prev_r & (warm_r == WARM_DONE);
  assign armed_s = TRIG_EN & is_sampling_state(current_state);

  // Next-state logic: IDLE -> FIRE on an armed edge, FIRE holds for the full
  // pulse width, then an optional HOLDOFF using the value latched at fire.
  always_comb begin
    state_n_s  = state_r;
    pcnt_n_s   = pcnt_r;
    ho_cnt_n_s = ho_cnt_r;
    case (state_r)
      TC_IDLE: begin
        if (edge_s && armed_s) begin
          state_n_s  = TC_FIRE;
          pcnt_n_s   = PULSE_LOAD;
          ho_cnt_n_s = HOLDOFF;
        end else begin
          state_n_s  = TC_IDLE;
        end
      end
      TC_FIRE: begin
        if (pcnt_r == 4'd0) begin
          if (ho_cnt_r != HO_ZERO) begin
            state_n_s = TC_HOLDOFF;
          end else begin
            state_n_s = TC_IDLE;
          end
        end else begin
          pcnt_n_s = pcnt_r - 4'd1;
        end
      end
      TC_HOLDOFF: begin
        if (ho_cnt_r <= HO_ONE) begin
          state_n_s  = TC_IDLE;
          ho_cnt_n_s = HO_ZERO;
        end else begin
          ho_cnt_n_s = ho_cnt_r - HO_ONE;
        end
      end
      default: begin
        state_n_s  = TC_IDLE;
        pcnt_n_s   = 4'd0;
        ho_cnt_n_s = HO_ZERO;
      end
    endcase
  end

  // FSM state, counters and registered trigger/busy derived from next state.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_r   <= TC_IDLE;
      pcnt_r    <= 4'd0;
      ho_cnt_r  <= HO_ZERO;
      trigger_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      pcnt_r    <= pcnt_n_s;
      ho_cnt_r  <= ho_cnt_n_s;
      trigger_r <= (state_n_s == TC_FIRE);
      busy_r    <= (state_n_s != TC_IDLE);
    end
  end

  // Saturating count of edges arriving while busy; clear wins over an edge.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      missed_r <= 8'd0;
    end else if (CLR_MISSED) begin
      missed_r <= 8'd0;
    end else if (edge_s && (state_r != TC_IDLE) && (missed_r != MISSED_MAX)) begin
      missed_r <= missed_r + 8'd1;
    end else begin
      missed_r <= missed_r;
    end
  end

  assign trigger    = trigger_r;
  assign busy       = busy_r;
  assign missed_cnt = missed_r;

endmodule

// File: tb/tb_ch_trigger_conditioner.sv
// Bench for ch_trigger_conditioner: an interval-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_ch_trigger_conditioner;
  import types_pkg::*;

  localparam int S  = 2;
  localparam int PW = 2;

  logic       CLK = 1'b0;
  logic       RSTB = 1'b1;
  logic       DISC = 1'b0;
  logic       TRIG_EN = 1'b1;
  logic [7:0] HOLDOFF = 8'd4;
  state_t     current_state = SAMPLING_A;
  logic       CLR_MISSED = 1'b0;
  logic       trigger;
  logic       busy;
  logic [7:0] missed_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int rise_cnt = 0;
  int hi_cnt = 0;

  ch_trigger_conditioner #(.SYNC_STAGES(S), .PULSE_W(PW), .HOLDOFF_W(8)) dut (
    .CLK           (CLK),
    .RSTB          (RSTB),
    .DISC          (DISC),
    .TRIG_EN       (TRIG_EN),
    .HOLDOFF       (HOLDOFF),
    .current_state (current_state),
    .CLR_MISSED    (CLR_MISSED),
    .trigger       (trigger),
    .busy          (busy),
    .missed_cnt    (missed_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bench_armed(input logic en, input state_t s);
    return en && (s inside {SAMPLING_A, SAMPLING_B, SAMPLING_C, SAMPLING_D,
                            SAMPLING_A_AND_B, SAMPLING_C_AND_D, SAMPLING_ALL});
  endfunction

  // Reference model: DISC samples since reset release, a fire time f and the
  // latched holdoff define the trigger and busy windows arithmetically.
  bit dh[$];
  bit fired = 1'b0;
  int f = 0;
  int hl = 0;
  int m_missed = 0;
  bit e_trig = 1'b0;
  bit e_busy = 1'b0;
  bit prev_trig = 1'b0;

  always begin
    int  now;
    bit  was_busy;
    bit  rise;
    @(posedge CLK or negedge RSTB);
    if (!RSTB) begin
      dh.delete();
      fired    = 1'b0;
      m_missed = 0;
      e_trig   = 1'b0;
      e_busy   = 1'b0;
    end else begin
      now      = dh.size();
      was_busy = fired && (now - 1 >= f) && (now - 1 < f + PW + hl);
      rise     = (now >= S + 1) && dh[now-S] && !dh[now-S-1];
      if (CLR_MISSED) m_missed = 0;
      else if (rise && was_busy && m_missed < 255) m_missed++;
      if (rise && !was_busy && bench_armed(TRIG_EN, current_state)) begin
        fired = 1'b1;
        f     = now;
        hl    = int'(HOLDOFF);
      end
      dh.push_back(DISC);
      e_trig = fired && (now >= f) && (now < f + PW);
      e_busy = fired && (now >= f) && (now < f + PW + hl);
    end
    #1;
    chk("model_trigger", int'(trigger), int'(e_trig));
    chk("model_busy", int'(busy), int'(e_busy));
    chk("model_missed", int'(missed_cnt), m_missed);
    if (trigger && !prev_trig) rise_cnt++;
    if (trigger) hi_cnt++;
    prev_trig = trigger;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic pulse(input int hi, input int lo);
    DISC = 1'b1;
    tick(hi);
    DISC = 1'b0;
    tick(lo);
  endtask

  initial begin
    int r0;
    int h0;
    int tr[16];
    int bz[16];
    int bsum;
    state_t gs[4];

    // Reset and arming/latency with HOLDOFF=4
    #1 RSTB = 1'b0;
    tick(3);
    chk("reset_trigger", int'(trigger), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_missed", int'(missed_cnt), 0);
    RSTB = 1'b1;
    tick(10);
    r0 = rise_cnt;
    DISC = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      tr[i] = int'(trigger);
      bz[i] = int'(busy);
    end
    chk("lat_edge_n1", tr[1], 0);
    chk("lat_edge_n2", tr[2], 1);
    chk("lat_edge_n3", tr[3], 1);
    chk("lat_edge_n4", tr[4], 0);
    bsum = 0;
    for (int i = 0; i < 16; i++) bsum += bz[i];
    chk("lat_busy_len", bsum, 6);
    chk("level_one_pulse", rise_cnt - r0, 1);
    DISC = 1'b0;
    tick(4);

    // Holdoff rejection with HOLDOFF=8
    HOLDOFF = 8'd8;
    tick(2);
    r0 = rise_cnt;
    pulse(2, 4);
    pulse(2, 20);
    chk("ho_rises1", rise_cnt - r0, 1);
    chk("ho_missed1", int'(missed_cnt), 1);
    pulse(2, 16);
    chk("ho_rises2", rise_cnt - r0, 2);
    chk("ho_missed2", int'(missed_cnt), 1);

    // Gating: unarmed states and disabled enable
    CLR_MISSED = 1'b1;
    tick(1);
    CLR_MISSED = 1'b0;
    chk("clr_missed", int'(missed_cnt), 0);
    gs[0] = SAMPLING_E;
    gs[1] = READOUT;
    gs[2] = STOPPED;
    gs[3] = SAMPLING_ALL;
    r0 = rise_cnt;
    for (int k = 0; k < 4; k++) begin
      current_state = gs[k];
      TRIG_EN = (k == 3) ? 1'b0 : 1'b1;
      pulse(2, 6);
    end
    chk("gate_rises", rise_cnt - r0, 0);
    chk("gate_missed", int'(missed_cnt), 0);

    // HOLDOFF=0 back-to-back pulses
    TRIG_EN = 1'b1;
    current_state = SAMPLING_B;
    HOLDOFF = 8'd0;
    tick(2);
    r0 = rise_cnt;
    h0 = hi_cnt;
    repeat (5) pulse(3, 3);
    tick(4);
    chk("b2b_rises", rise_cnt - r0, 5);
    chk("b2b_high_cycles", hi_cnt - h0, 10);

    // Saturation, then clear coinciding with a rejected edge
    HOLDOFF = 8'd255;
    current_state = SAMPLING_ALL;
    repeat (300) pulse(1, 1);
    chk("sat_missed", int'(missed_cnt), 255);
    tick(300);
    r0 = rise_cnt;
    pulse(1, 5);
    chk("sat_fire", rise_cnt - r0, 1);
    CLR_MISSED = 1'b1;
    DISC = 1'b1;
    tick(1);
    DISC = 1'b0;
    tick(3);
    CLR_MISSED = 1'b0;
    tick(2);
    chk("clr_vs_edge", int'(missed_cnt), 0);
    HOLDOFF = 8'd2;
    tick(300);

    // Edge in the last holdoff cycle is missed
    HOLDOFF = 8'd3;
    current_state = SAMPLING_C_AND_D;
    tick(2);
    r0 = rise_cnt;
    pulse(2, 3);
    DISC = 1'b1;
    tick(2);
    DISC = 1'b0;
    tick(10);
    chk("last_ho_rises", rise_cnt - r0, 1);
    chk("last_ho_missed", int'(missed_cnt), 1);

    // Reset mid-pulse, then level held high across release
    DISC = 1'b1;
    tick(3);
    chk("rst_pre_trigger", int'(trigger), 1);
    tick(1);
    RSTB = 1'b0;
    #1;
    chk("rst_trigger", int'(trigger), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_missed", int'(missed_cnt), 0);
    tick(2);
    RSTB = 1'b1;
    r0 = rise_cnt;
    tick(12);
    chk("rst_level_no_fire", rise_cnt - r0, 0);
    DISC = 1'b0;
    tick(3);
    DISC = 1'b1;
    tick(5);
    chk("rst_refire", rise_cnt - r0, 1);
    DISC = 1'b0;
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
